// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and a constant-evaluable ceiling-log2 used to size the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bi, with borrow-out bo.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference bit and borrow generation/propagation.
  always_comb begin
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: D = X - Y - BIN, one bit per clock, LSB first.
// Operands are captured on an accepted start, shifted right through a single
// full-subtractor cell, and the result is published to d/bout only on the
// final bit so the outputs hold steady across a following operation.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] xs_reg;
  logic [WIDTH-1:0] ys_reg;
  logic [WIDTH-1:0] pr_reg;
  logic [WIDTH-1:0] d_reg;
  logic             bout_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;

  logic             accept;
  logic             last_bit;
  logic             di;
  logic             bo;
  logic [WIDTH-1:0] pr_shifted;

  // A request is honoured only when no operation is in flight.
  assign accept     = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_bit   = (cnt_reg == LAST);
  assign pr_shifted = {di, pr_reg[WIDTH-1:1]};

  full_subtractor fs_cell (
    .a  (xs_reg[0]),
    .b  (ys_reg[0]),
    .bi (borrow_reg),
    .d  (di),
    .bo (bo)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; start during RUN is deliberately ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs decoded straight from the registered state.
  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  // Operand capture, serial shift/borrow datapath and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      xs_reg     <= '0;
      ys_reg     <= '0;
      pr_reg     <= '0;
      d_reg      <= '0;
      bout_reg   <= 1'b0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (accept) begin
      xs_reg     <= x;
      ys_reg     <= y;
      borrow_reg <= bin;
      cnt_reg    <= '0;
    end else if (state_reg == RUN) begin
      xs_reg     <= xs_reg >> 1;
      ys_reg     <= ys_reg >> 1;
      pr_reg     <= pr_shifted;
      borrow_reg <= bo;
      cnt_reg    <= cnt_reg + 1'b1;
      if (last_bit) begin
        d_reg    <= pr_shifted;
        bout_reg <= bo;
      end
    end
  end

  assign d    = d_reg;
  assign bout = bout_reg;

endmodule
